// File: rtl/regfile_pkg.sv
// Shared constants and encodings for the register-file write arbiter.
// Data/address widths, requester IDs and round-robin priority states.
package regfile_pkg;

  localparam int REG_DW = 32;
  localparam int REG_AW = 5;
  localparam int REG_N  = 32;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter owning the priority pointer flop.
// Ports: clk, rst (async active-low), req[1:0], hold -> gnt[1:0].
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  prio_e prio_q, prio_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= PRIO_A;
    else      prio_q <= prio_d;
  end

  // After any grant, priority passes to the other requester.
  always_comb begin
    prio_d = prio_q;
    if (gnt[REQ_A])      prio_d = PRIO_B;
    else if (gnt[REQ_B]) prio_d = PRIO_A;
  end

  // Grants are suppressed during reset so ready stays low.
  always_comb begin
    gnt = 2'b00;
    if (rst && !hold) begin
      if (req[REQ_A] &&
          (!req[REQ_B] || prio_q == PRIO_A))
        gnt[REQ_A] = 1'b1;
      else if (req[REQ_B])
        gnt[REQ_B] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between A (write-back) and B (load/debug).
// Ports: a_/b_ valid/addr/data/ready, hold, reg_sel, reg_wdata, rd_addr, fwd_hit, fwd_data.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW,
  parameter int NREGS = REG_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  input  logic             hold,
  output logic [NREGS-1:0] reg_sel,
  output logic [DW-1:0]    reg_wdata,
  input  logic [AW-1:0]    rd_addr,
  output logic             fwd_hit,
  output logic [DW-1:0]    fwd_data
);

  logic [1:0]       gnt;
  logic             grant;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;

  logic             pend_valid_q, pend_valid_d;
  logic [AW-1:0]    pend_addr_q, pend_addr_d;
  logic [DW-1:0]    pend_data_q, pend_data_d;
  logic [NREGS-1:0] reg_sel_q, reg_sel_d;
  logic [DW-1:0]    reg_wdata_q, reg_wdata_d;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({b_valid, a_valid}),
    .hold (hold),
    .gnt  (gnt)
  );

  assign a_ready = gnt[REQ_A];
  assign b_ready = gnt[REQ_B];
  assign grant   = |gnt;
  assign w_addr  = gnt[REQ_B] ? b_addr : a_addr;
  assign w_data  = gnt[REQ_B] ? b_data : a_data;

  always_comb begin
    pend_valid_d = grant;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    reg_wdata_d  = reg_wdata_q;
    if (grant) begin
      pend_addr_d = w_addr;
      pend_data_d = w_data;
      reg_wdata_d = w_data;
    end
  end

  // x0 is hardwired zero: never select it.
  always_comb begin
    reg_sel_d = '0;
    if (grant && w_addr != '0)
      reg_sel_d[w_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      reg_sel_q    <= '0;
      reg_wdata_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      reg_sel_q    <= reg_sel_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign reg_sel   = reg_sel_q;
  assign reg_wdata = reg_wdata_q;
  assign fwd_hit   = pend_valid_q &&
                     pend_addr_q == rd_addr &&
                     rd_addr != '0;
  assign fwd_data  = pend_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter.
// Drives on negedge, checks comb outputs before and registered outputs after posedge.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, hold;
  logic [4:0]  a_addr, b_addr, rd_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, fwd_hit;
  logic [31:0] reg_sel, reg_wdata, fwd_data;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .hold      (hold),
    .reg_sel   (reg_sel),
    .reg_wdata (reg_wdata),
    .rd_addr   (rd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pre;
    @(negedge clk);
  endtask

  task automatic post;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
    rd_addr = 5'd0;

    // 1: reset state, then single A write
    #2;
    chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
    chk("rst_reg_sel", reg_sel, 32'h0);
    chk("rst_wdata", reg_wdata, 32'h0);
    chk("rst_fwd_hit", {31'b0, fwd_hit}, 32'd0);
    pre;
    rst = 1'b1; a_data = 32'hDEADBEEF;
    #1;
    chk("t1_a_ready", {31'b0, a_ready}, 32'd1);
    chk("t1_b_ready", {31'b0, b_ready}, 32'd0);
    post;
    a_valid = 1'b0;
    chk("t1_sel", reg_sel, 32'h0000_0020);
    chk("t1_wdata", reg_wdata, 32'hDEADBEEF);
    post;
    chk("t1_sel_clr", reg_sel, 32'h0);
    chk("t1_wdata_hold", reg_wdata, 32'hDEADBEEF);

    // Restore prio=A with a reset pulse
    pre; rst = 1'b0;
    pre; rst = 1'b1;

    // 2: both valid for four cycles -> A,B,A,B
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_a_ready", {31'b0, a_ready},
          (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_b_ready", {31'b0, b_ready},
          (i % 2 == 0) ? 32'd0 : 32'd1);
      post;
      chk("t2_sel", reg_sel,
          (i % 2 == 0) ? 32'h08 : 32'h10);
      chk("t2_wdata", reg_wdata,
          (i % 2 == 0) ? 32'h1111 : 32'h2222);
      pre;
    end
    b_valid = 1'b0;

    // 3: write to x0
    a_addr = 5'd0; a_data = 32'h1234; rd_addr = 5'd0;
    #1;
    chk("t3_a_ready", {31'b0, a_ready}, 32'd1);
    post;
    a_valid = 1'b0;
    chk("t3_sel", reg_sel, 32'h0);
    chk("t3_wdata", reg_wdata, 32'h1234);
    chk("t3_fwd_hit", {31'b0, fwd_hit}, 32'd0);

    // 4: forwarding of in-flight write
    pre;
    a_valid = 1'b1; a_addr = 5'd7;
    a_data = 32'hA5A5A5A5; rd_addr = 5'd7;
    #1;
    chk("t4_a_ready", {31'b0, a_ready}, 32'd1);
    chk("t4_fwd_pre", {31'b0, fwd_hit}, 32'd0);
    post;
    a_valid = 1'b0;
    chk("t4_fwd_hit", {31'b0, fwd_hit}, 32'd1);
    chk("t4_fwd_data", fwd_data, 32'hA5A5A5A5);
    chk("t4_sel", reg_sel, 32'h80);
    post;
    chk("t4_fwd_clr", {31'b0, fwd_hit}, 32'd0);

    // 5: grant A, then hold with both valid
    pre;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    #1;
    chk("t5_a_ready", {31'b0, a_ready}, 32'd1);
    post;
    chk("t5_sel", reg_sel, 32'h200);
    pre;
    hold = 1'b1;
    a_addr = 5'd10; a_data = 32'hAA;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_a", {31'b0, a_ready}, 32'd0);
      chk("t5_hold_b", {31'b0, b_ready}, 32'd0);
      post;
      chk("t5_hold_sel", reg_sel, 32'h0);
      pre;
    end
    hold = 1'b0;
    #1;
    chk("t5_b_first", {31'b0, b_ready}, 32'd1);
    chk("t5_a_wait", {31'b0, a_ready}, 32'd0);
    post;
    chk("t5_sel_b", reg_sel, 32'h800);
    chk("t5_wdata_b", reg_wdata, 32'hBB);
    pre;
    b_valid = 1'b0;
    #1;
    chk("t5_a_next", {31'b0, a_ready}, 32'd1);
    post;
    chk("t5_sel_a", reg_sel, 32'h400);
    pre;
    a_valid = 1'b0;

    // 6: async reset mid-cycle drops in-flight write
    a_valid = 1'b1; a_addr = 5'd12;
    a_data = 32'hC0C0; rd_addr = 5'd12;
    post;
    chk("t6_sel", reg_sel, 32'h1000);
    chk("t6_fwd_hit", {31'b0, fwd_hit}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_sel", reg_sel, 32'h0);
    chk("t6_rst_fwd", {31'b0, fwd_hit}, 32'd0);
    chk("t6_rst_wdata", reg_wdata, 32'h0);
    chk("t6_rst_ready", {31'b0, a_ready}, 32'd0);
    pre;
    rst = 1'b1;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD0D0;
    #1;
    chk("t6_prio_a", {31'b0, a_ready}, 32'd1);
    chk("t6_prio_b", {31'b0, b_ready}, 32'd0);
    chk("t6_pend_clr", {31'b0, fwd_hit}, 32'd0);
    post;
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t6_sel_after", reg_sel, 32'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
